// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the program-RAM arbiter: default geometry, port ids
// used to tag a response with the requester that owns it, and the response
// bundle carried from the RAM back to a requester.
// ---------------------------------------------------------------------------
package ram_pkg;

    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 2048;
    localparam int STARVE_LIMIT = 4;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the fetch port, the loader port and the RAM macro side of the
// arbiter.
//   slave  : arbiter view (takes requests and RAM read data, drives
//            ready/response/RAM strobes)
//   master : environment view (CPU fetch, loader and RAM macro together)
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
);
    // fetch port (read-only)
    logic              f_valid;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ready;
    logic              f_rsp_valid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;
    // loader / debug port
    logic              l_valid;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_ready;
    logic              l_rsp_valid;
    logic [DATA_W-1:0] l_rdata;
    logic              l_err;
    // RAM macro
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, l_lock, ram_rdata,
        output f_ready, f_rsp_valid, f_rdata, f_err,
               l_ready, l_rsp_valid, l_rdata, l_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, l_lock, ram_rdata,
        input  f_ready, f_rsp_valid, f_rdata, f_err,
               l_ready, l_rsp_valid, l_rdata, l_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arb_grant.sv
// ---------------------------------------------------------------------------
// ram_arb_grant
// Per-cycle grant decision between fetch and loader, plus the loader
// starvation counter.
//   CLK, RST          clock, asynchronous active-high reset
//   f_valid, l_valid  request strobes
//   l_lock            loader lock: fetch never granted while high
//   f_gnt, l_gnt      one-hot (or zero) grant, combinational
// ---------------------------------------------------------------------------
module ram_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic f_valid,
    input  logic l_valid,
    input  logic l_lock,
    output logic f_gnt,
    output logic l_gnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= LIMIT) ? LIMIT : v + 8'd1;
    endfunction

    // Grants are held off while reset is asserted so every output is quiet.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!RST) begin
            if (l_lock) begin
                l_gnt = l_valid;
            end else if (f_valid && l_valid) begin
                if (starve_cnt >= LIMIT) l_gnt = 1'b1;
                else                     f_gnt = 1'b1;
            end else begin
                f_gnt = f_valid;
                l_gnt = l_valid;
            end
        end
    end

    // Counts consecutive cycles a waiting loader was denied.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                   starve_cnt <= 8'd0;
        else if (!l_valid || l_gnt) starve_cnt <= 8'd0;
        else                       starve_cnt <= sat_inc(starve_cnt);
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port program RAM between CPU instruction fetch (fixed
// priority, read-only) and the loader/debug port (read/write, starvation
// guard, fetch lock). One access per cycle; response exactly one cycle after
// the grant, on the winning port only.
//   CLK   system clock
//   RST   asynchronous active-high reset
//   bus   ram_arbiter_if.slave: fetch port, loader port, RAM macro strobes
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W       = ram_pkg::ADDR_W,
    parameter int DATA_W       = ram_pkg::DATA_W,
    parameter int DEPTH        = ram_pkg::DEPTH,
    parameter int STARVE_LIMIT = ram_pkg::STARVE_LIMIT
) (
    input logic          CLK,
    input logic          RST,
    ram_arbiter_if.slave bus
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              f_gnt;
    logic              l_gnt;
    logic              gnt_any;
    logic              in_range;
    logic [ADDR_W-1:0] gnt_addr;

    logic vld_p1;
    logic port_p1;
    logic err_p1;
    logic rd_p1;

    rsp_t rsp;
    rsp_t f_rsp;
    rsp_t l_rsp;

    ram_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .CLK     (CLK),
        .RST     (RST),
        .f_valid (bus.f_valid),
        .l_valid (bus.l_valid),
        .l_lock  (bus.l_lock),
        .f_gnt   (f_gnt),
        .l_gnt   (l_gnt)
    );

    assign bus.f_ready = f_gnt;
    assign bus.l_ready = l_gnt;

    // Stage 0: winner drives the RAM in the grant cycle
    always_comb begin
        gnt_any  = f_gnt | l_gnt;
        gnt_addr = '0;
        if (l_gnt)      gnt_addr = bus.l_addr;
        else if (f_gnt) gnt_addr = bus.f_addr;
        in_range      = ({1'b0, gnt_addr} < DEPTH_L);
        bus.ram_en    = gnt_any & in_range;
        bus.ram_we    = l_gnt & bus.l_we;
        bus.ram_addr  = gnt_addr;
        bus.ram_wdata = l_gnt ? bus.l_wdata : '0;
    end

    // Stage 1: response tag registered, read data taken straight from the RAM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            port_p1 <= PORT_FETCH;
            err_p1  <= 1'b0;
            rd_p1   <= 1'b0;
        end else begin
            vld_p1  <= gnt_any;
            port_p1 <= l_gnt ? PORT_LOAD : PORT_FETCH;
            err_p1  <= gnt_any & ~in_range;
            rd_p1   <= gnt_any & in_range & ~bus.ram_we;
        end
    end

    // Writes and out-of-range accesses return zero data.
    always_comb begin
        rsp       = '0;
        rsp.valid = vld_p1;
        rsp.err   = err_p1;
        rsp.rdata = rd_p1 ? bus.ram_rdata : '0;
        f_rsp     = (port_p1 == PORT_FETCH) ? rsp : '0;
        l_rsp     = (port_p1 == PORT_LOAD)  ? rsp : '0;
    end

    assign bus.f_rsp_valid = f_rsp.valid;
    assign bus.f_err       = f_rsp.err;
    assign bus.f_rdata     = f_rsp.rdata;
    assign bus.l_rsp_valid = l_rsp.valid;
    assign bus.l_err       = l_rsp.err;
    assign bus.l_rdata     = l_rsp.rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Bench for ram_arbiter with DEPTH=2000 and STARVE_LIMIT=4. A behavioural RAM
// macro answers the RAM strobes; a reference model (per-cycle grant rule,
// denied-cycle count, shadow memory) predicts ready, RAM drive and responses
// and is compared every falling edge. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2000;
    localparam int LIMIT = 4;

    logic CLK = 1'b0;
    logic RST;

    int errors = 0;
    int checks = 0;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #31.25 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h1000_0000;
            1:       return 32'h1000_0001;
            2:       return 32'h1000_0002;
            3:       return 32'h2000_0001;
            5:       return 32'hA5A5_A5A5;
            2047:    return 32'hDEAD_BEEF;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural RAM macro: 1-cycle read latency.
    logic [31:0] mem [0:2047];
    logic        mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    // Reference model and per-cycle compare.
    logic [31:0] ref_mem [0:2047];
    logic        ref_init = 1'b0;
    int          m_denied = 0;
    logic        e_fv = 1'b0, e_lv = 1'b0, e_err = 1'b0;
    logic [31:0] e_data = '0;

    always @(negedge CLK) begin
        logic        fg, lg, inr, wr;
        int          a;
        if (!ref_init) begin
            for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (RST) begin
            chk("rst f_ready",     bus.f_ready,     0);
            chk("rst l_ready",     bus.l_ready,     0);
            chk("rst f_rsp_valid", bus.f_rsp_valid, 0);
            chk("rst f_rdata",     bus.f_rdata,     0);
            chk("rst f_err",       bus.f_err,       0);
            chk("rst l_rsp_valid", bus.l_rsp_valid, 0);
            chk("rst l_rdata",     bus.l_rdata,     0);
            chk("rst l_err",       bus.l_err,       0);
            chk("rst ram_en",      bus.ram_en,      0);
            chk("rst ram_we",      bus.ram_we,      0);
            chk("rst ram_addr",    bus.ram_addr,    0);
            chk("rst ram_wdata",   bus.ram_wdata,   0);
            m_denied = 0;
            e_fv = 1'b0;
            e_lv = 1'b0;
        end else begin
            chk("m f_rsp_valid", bus.f_rsp_valid, e_fv);
            chk("m l_rsp_valid", bus.l_rsp_valid, e_lv);
            if (e_fv) begin
                chk("m f_err",   bus.f_err,   e_err);
                chk("m f_rdata", bus.f_rdata, e_data);
            end
            if (e_lv) begin
                chk("m l_err",   bus.l_err,   e_err);
                chk("m l_rdata", bus.l_rdata, e_data);
            end
            fg = 1'b0;
            lg = 1'b0;
            if (bus.l_lock)                      lg = bus.l_valid;
            else if (bus.f_valid && bus.l_valid) begin
                if (m_denied == LIMIT) lg = 1'b1;
                else                   fg = 1'b1;
            end else begin
                fg = bus.f_valid;
                lg = bus.l_valid;
            end
            a   = lg ? int'(bus.l_addr) : int'(bus.f_addr);
            inr = (a < DEPTH);
            wr  = lg && bus.l_we;
            chk("m f_ready", bus.f_ready, fg);
            chk("m l_ready", bus.l_ready, lg);
            chk("m ram_en",  bus.ram_en,  (fg || lg) && inr);
            chk("m ram_we",  bus.ram_we,  wr);
            if (fg || lg)       chk("m ram_addr",  bus.ram_addr,  a);
            if (wr && inr)      chk("m ram_wdata", bus.ram_wdata, bus.l_wdata);
            m_denied = (bus.l_valid && !lg) ? ((m_denied < LIMIT) ? m_denied + 1 : LIMIT) : 0;
            e_fv   = fg;
            e_lv   = lg;
            e_err  = (fg || lg) && !inr;
            e_data = ((fg || lg) && inr && !wr) ? ref_mem[a] : 32'h0;
            if (wr && inr) ref_mem[a] = bus.l_wdata;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        bus.f_valid = 0; bus.f_addr = '0;
        bus.l_valid = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 0;
        step();
        bus.f_valid = 1; bus.f_addr = 11'd7;
        @(negedge CLK);
        chk("reset f_ready", bus.f_ready, 0);
        chk("reset ram_en",  bus.ram_en,  0);
        step();
        bus.f_valid = 0;
        RST = 1'b0;

        // reset mid-read
        step();
        bus.f_valid = 1; bus.f_addr = 11'd5;
        @(negedge CLK);
        chk("midrst f_ready", bus.f_ready, 1);
        step();
        bus.f_valid = 0;
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst f_rsp_valid in rst", bus.f_rsp_valid, 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst f_rsp_valid after", bus.f_rsp_valid, 0);
        step();
        @(negedge CLK);
        chk("midrst f_rsp_valid later", bus.f_rsp_valid, 0);

        // solo fetch
        step();
        bus.f_valid = 1; bus.f_addr = 11'd3;
        @(negedge CLK);
        chk("solo f_ready", bus.f_ready, 1);
        step();
        bus.f_valid = 0;
        @(negedge CLK);
        chk("solo f_rsp_valid", bus.f_rsp_valid, 1);
        chk("solo f_rdata",     bus.f_rdata,     32'h2000_0001);
        chk("solo f_err",       bus.f_err,       0);

        // contention: loader wins one cycle in five
        step();
        bus.f_valid = 1; bus.f_addr = 11'd0;
        bus.l_valid = 1; bus.l_we = 0; bus.l_addr = 11'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("starve l_ready", bus.l_ready, (i % 5) == 4);
            chk("starve f_ready", bus.f_ready, (i % 5) != 4);
            step();
        end
        bus.f_valid = 0; bus.l_valid = 0;
        @(negedge CLK);
        chk("starve l_rdata", bus.l_rdata, 32'h1000_0001);

        // lock + write, then fetch the same word
        step();
        bus.l_lock = 1; bus.l_valid = 1; bus.l_we = 1; bus.l_addr = 11'd8; bus.l_wdata = 32'h3000_0000;
        bus.f_valid = 1; bus.f_addr = 11'd8;
        @(negedge CLK);
        chk("lock f_ready", bus.f_ready, 0);
        chk("lock l_ready", bus.l_ready, 1);
        step();
        bus.l_lock = 0; bus.l_valid = 0; bus.l_we = 0;
        @(negedge CLK);
        chk("lock l_rsp_valid", bus.l_rsp_valid, 1);
        chk("lock l_rdata",     bus.l_rdata,     0);
        chk("unlock f_ready",   bus.f_ready,     1);
        step();
        bus.f_valid = 0;
        @(negedge CLK);
        chk("wr-rd f_rsp_valid", bus.f_rsp_valid, 1);
        chk("wr-rd f_rdata",     bus.f_rdata,     32'h3000_0000);

        // out of range write and read
        step();
        bus.l_valid = 1; bus.l_we = 1; bus.l_addr = 11'd2047; bus.l_wdata = 32'h1234_5678;
        @(negedge CLK);
        chk("oor ram_en",  bus.ram_en,  0);
        chk("oor l_ready", bus.l_ready, 1);
        step();
        bus.l_valid = 0; bus.l_we = 0;
        @(negedge CLK);
        chk("oor l_rsp_valid", bus.l_rsp_valid, 1);
        chk("oor l_err",       bus.l_err,       1);
        chk("oor l_rdata",     bus.l_rdata,     0);
        chk("oor mem kept",    mem[2047],       32'hDEAD_BEEF);
        step();
        bus.f_valid = 1; bus.f_addr = 11'd2000;
        @(negedge CLK);
        chk("oor rd ram_en", bus.ram_en, 0);
        step();
        bus.f_valid = 0;
        @(negedge CLK);
        chk("oor rd f_err",   bus.f_err,   1);
        chk("oor rd f_rdata", bus.f_rdata, 0);

        // back-to-back fetches
        step();
        bus.f_valid = 1; bus.f_addr = 11'd0;
        @(negedge CLK);
        chk("b2b f_ready", bus.f_ready, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i < 3) bus.f_addr = 11'(i);
            else       bus.f_valid = 0;
            @(negedge CLK);
            chk("b2b f_rsp_valid", bus.f_rsp_valid, 1);
            chk("b2b f_rdata",     bus.f_rdata,     32'h1000_0000 + 32'(i - 1));
        end
        step();
        @(negedge CLK);
        chk("b2b f_rsp_valid end", bus.f_rsp_valid, 0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port 32-bit program RAM between two requesters: the CPU instruction-fetch port (read-only) and the program loader/debug port (read/write).
- Fetch has fixed priority.
- The loader has a starvation guard and a lock that freezes fetch while a program is being written.
- Sits between the CPU core, the loader and the RAM macro; one RAM access per cycle, 1-cycle read latency.

Parameters:
ADDR_W, 11, RAM address width
DATA_W, 32, RAM word width
DEPTH, 2048, number of valid RAM words; addresses >= DEPTH are out of range
STARVE_LIMIT, 4, consecutive denied cycles after which a waiting loader request wins over fetch (1..255)

Ports:
CLK  in  1  system clock (16 MHz)
RST  in  1  asynchronous, active-high reset
f_valid  in  1  fetch read request
f_addr  in  ADDR_W  fetch address
f_ready  out  1  fetch request accepted this cycle
f_rsp_valid  out  1  fetch read data valid
f_rdata  out  DATA_W  fetch read data
f_err  out  1  with f_rsp_valid: address out of range
l_valid  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_lock  in  1  block all fetch grants while high
l_ready  out  1  loader request accepted this cycle
l_rsp_valid  out  1  loader response (read data or write ack)
l_rdata  out  DATA_W  loader read data; 0 for writes
l_err  out  1  with l_rsp_valid: address out of range
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en & !ram_we

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- Reset values: all outputs 0, including the registered response outputs, with starve_cnt=0. Any pending response is discarded; no rsp_valid pulse appears after RST deasserts for a pre-reset request.
- Handshake:
  - A request is accepted in the cycle where valid & ready.
  - The requester holds addr/we/wdata stable until accepted.
  - ready is combinational from valid, l_lock and starve_cnt.
  - Responses cannot be back-pressured.
- Grant decision (per cycle, at most one grant):
  - l_lock=1: f_ready=0; l_ready=l_valid.
  - else f_valid & l_valid & starve_cnt<STARVE_LIMIT: fetch granted.
  - else f_valid & l_valid & starve_cnt==STARVE_LIMIT: loader granted.
  - else: whichever single requester is valid is granted.
- starve_cnt (8 bit):
  - +1 each cycle l_valid & !l_ready.
  - Cleared on loader grant, or when l_valid=0.
  - Saturates at STARVE_LIMIT.
- RAM drive, in the grant cycle (combinational):
  - ram_en=1 only if the granted addr < DEPTH.
  - ram_we = l_we for loader grants, 0 for fetch grants.
  - ram_addr/ram_wdata from the winner.
- Out of range: no RAM access; response still issued with err=1, rdata=0. Writes are dropped.
- Response pipeline (registered, latency exactly 1):
  - Grant in cycle N gives the winner's rsp_valid=1 in cycle N+1 for one cycle.
  - rdata = ram_rdata for in-range reads, 0 otherwise.
  - The other port's rsp_valid stays 0.
- Throughput: back-to-back grants every cycle. A loader write in N followed by a fetch read of the same address in N+1 returns the new data.
- l_lock rising while a fetch response is pending: that response still completes in the next cycle.

Decomposition:
- Shared package ram_pkg:
  - ADDR_W, DATA_W, DEPTH defaults.
  - Port-id constants PORT_FETCH=0, PORT_LOAD=1.
  - Response struct {valid, err, rdata}.
- One sub-module, ram_arb_grant: the combinational grant + starve_cnt register.
- The top holds the RAM drive and response registers.
- The RAM macro stays outside this block.

Test Plan:
- Reset mid-read: f_valid, f_addr=5 accepted; RST pulsed during the following cycle -> f_rsp_valid stays 0 after release; all outputs 0 during reset.
- Solo fetch: ram[3]=0x20000001; f_valid, f_addr=3 -> f_ready=1 in N, f_rsp_valid=1, f_rdata=0x20000001 in N+1.
- Contention/starvation (STARVE_LIMIT=4): f_valid and l_valid held continuously -> fetch granted 4 cycles, loader granted 5th, pattern repeats (loader 1 in 5).
- Lock + write-then-read: l_lock=1, l_we=1, l_addr=8, l_wdata=0x30000000 with f_valid=1 -> f_ready=0, l_rsp_valid=1, l_rdata=0 next cycle. Then lock dropped, fetch addr 8 -> f_rdata=0x30000000.
- Out of range: l_we=1, l_addr=2047 (DEPTH=2000) -> ram_en=0, next cycle l_rsp_valid=1, l_err=1, l_rdata=0; RAM contents unchanged.
- Back-to-back: fetch addrs 0,1,2 on consecutive cycles -> f_rsp_valid high 3 consecutive cycles, data in order.
